// File: rtl/kyber_sched_pkg.sv
// Shared definitions for the Kyber bank access scheduler.
// Holds lane/bank geometry, the identity bank permutation used as the
// reset value of out_bank, and the scheduler state encoding.
package kyber_sched_pkg;

  localparam int LANES  = 4;
  localparam int BANKS  = 4;
  localparam int BANK_W = 2;

  // Lane i -> bank i, packed lane3..lane0.
  localparam logic [LANES*BANK_W-1:0] BANK_IDENTITY = 8'b11_10_01_00;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

endpackage

// File: rtl/sched_grant.sv
// Combinational grant and bank-fill logic for one beat.
// Ports:
//   pend      in  pending lane mask
//   bank_in   in  per-lane bank index, lane i in bits [2i+1:2i]
//   grant     out lanes granted this beat (no two share a bank)
//   bank_fill out per-lane bank index forming a full permutation of 0..3
// Granted lanes keep their bank; the remaining lanes take the unused banks
// in ascending order so the downstream arbiter always sees a one-to-one map.
module sched_grant
  import kyber_sched_pkg::*;
(
  input  logic [LANES-1:0]        pend,
  input  logic [LANES*BANK_W-1:0] bank_in,
  output logic [LANES-1:0]        grant,
  output logic [LANES*BANK_W-1:0] bank_fill
);

  logic [BANKS-1:0] used;
  logic             found;

  always_comb begin
    grant     = '0;
    bank_fill = '0;
    used      = '0;
    found     = 1'b0;
    // Lowest pending lane claims each bank first.
    for (int i = 0; i < LANES; i++) begin
      if (pend[i] && !used[bank_in[i*BANK_W +: BANK_W]]) begin
        grant[i]                      = 1'b1;
        used[bank_in[i*BANK_W +: BANK_W]] = 1'b1;
        bank_fill[i*BANK_W +: BANK_W] = bank_in[i*BANK_W +: BANK_W];
      end
    end
    // Non-granted lanes soak up the leftover banks, lowest first.
    for (int i = 0; i < LANES; i++) begin
      if (!grant[i]) begin
        found = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
          if (!found && !used[b]) begin
            bank_fill[i*BANK_W +: BANK_W] = BANK_W'(b);
            used[b]                       = 1'b1;
            found                         = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bank_access_scheduler.sv
// Bank access scheduler: splits a four-lane coefficient access group into
// conflict-free beats for the downstream four-lane bank arbiter.
// Optional feature macro: SCHED_STATS_EN (adds stats_clr / stall_cnt).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready group handshake; in_bank/in_addr/in_mask group fields
//   out_valid/out_ready beat handshake
//   out_bank          per-lane bank, always a permutation of 0..3
//   out_addr          per-lane word address of the latched group
//   out_lane_en       lanes granted this beat
//   out_last          beat completes the group
//   stats_clr         (SCHED_STATS_EN) synchronous clear of stall_cnt
//   stall_cnt         (SCHED_STATS_EN) saturating count of non-last beats
module bank_access_scheduler
  import kyber_sched_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*BANK_W-1:0] in_bank,
  input  logic [LANES*AW-1:0]     in_addr,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BANK_W-1:0] out_bank,
  output logic [LANES*AW-1:0]     out_addr,
  output logic [LANES-1:0]        out_lane_en,
  output logic                    out_last
`ifdef SCHED_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [15:0]             stall_cnt
`endif
);

  state_t                  state, state_nxt;
  logic                    run;
  logic [LANES-1:0]        pend;
  logic [LANES*BANK_W-1:0] bank_q;

  logic                    load;
  logic                    beat;
  logic [LANES-1:0]        rem;
  logic [LANES-1:0]        g_pend;
  logic [LANES*BANK_W-1:0] g_bank;
  logic [LANES-1:0]        g_grant;
  logic [LANES*BANK_W-1:0] g_fill;
  logic                    g_last;

  assign load = in_valid && in_ready && (in_mask != '0);
  assign beat = out_valid && out_ready;
  assign rem  = pend & ~out_lane_en;

  // One grant unit serves both a freshly accepted group and the remainder
  // of the current group; a load only happens once the group is finished.
  assign g_pend = load ? in_mask : rem;
  assign g_bank = load ? in_bank : bank_q;
  assign g_last = ((g_pend & ~g_grant) == '0);

  sched_grant u_grant (
    .pend      (g_pend),
    .bank_in   (g_bank),
    .grant     (g_grant),
    .bank_fill (g_fill)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (load)                    state_nxt = S_ISSUE;
        else if (beat && rem == '0)  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: ready when idle or when the final beat leaves this cycle.
  // run keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = run && ((state == S_IDLE) || (out_last && out_ready));
  end

  // Beat registers: pending mask, latched banks and all out_* signals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      pend        <= '0;
      bank_q      <= '0;
      out_valid   <= 1'b0;
      out_lane_en <= '0;
      out_last    <= 1'b0;
      out_bank    <= BANK_IDENTITY;
      out_addr    <= '0;
    end else begin
      run <= 1'b1;
      if (load) begin
        pend        <= in_mask;
        bank_q      <= in_bank;
        out_addr    <= in_addr;
        out_valid   <= 1'b1;
        out_lane_en <= g_grant;
        out_bank    <= g_fill;
        out_last    <= g_last;
      end else if (beat) begin
        pend <= rem;
        if (rem != '0) begin
          out_valid   <= 1'b1;
          out_lane_en <= g_grant;
          out_bank    <= g_fill;
          out_last    <= g_last;
        end else begin
          out_valid   <= 1'b0;
          out_lane_en <= '0;
          out_last    <= 1'b0;
        end
      end
    end
  end

`ifdef SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  stall_cnt <= '0;
    else if (stats_clr)          stall_cnt <= '0;
    else if (beat && !out_last)  stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_bank_access_scheduler.sv
`timescale 1ns/1ps
module tb_bank_access_scheduler;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [7:0]      in_bank, out_bank;
  logic [4*AW-1:0] in_addr, out_addr;
  logic [3:0]      in_mask, out_lane_en;
  logic            out_valid, out_ready, out_last;
`ifdef SCHED_STATS_EN
  logic            stats_clr;
  logic [15:0]     stall_cnt;
  int              stall_exp = 0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int         exp_n;
  logic [3:0] exp_en[4];
  logic [7:0] exp_ob[4];
  bit         chk_ob_all;

  typedef struct {
    logic [7:0]  bank;
    logic [3:0]  mask;
    int          n;
    logic [15:0] en;    // beat k lane enables in bits [4k+3:4k]
    logic [7:0]  ob1;   // out_bank of the first beat
    int          hold0; // cycles out_ready stays low on the first beat
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  bank_access_scheduler #(.AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bank     (in_bank),
    .in_addr     (in_addr),
    .in_mask     (in_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bank    (out_bank),
    .out_addr    (out_addr),
    .out_lane_en (out_lane_en),
    .out_last    (out_last)
`ifdef SCHED_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_perm(input logic [7:0] ob);
    logic [3:0] seen;
    seen = '0;
    for (int l = 0; l < 4; l++) seen[ob[2*l +: 2]] = 1'b1;
    return seen == 4'hF;
  endfunction

  // Reference: each bank serves its lowest pending lane per beat; unused
  // banks go to the idle lanes in ascending order.
  task automatic model(input logic [7:0] b, input logic [3:0] m);
    logic [3:0] p;
    logic [3:0] g;
    logic [7:0] ob;
    int         free_q[$];
    bit         busy;
    int         n;
    p = m;
    n = 0;
    while (p != 0) begin
      g = '0;
      for (int bk = 0; bk < 4; bk++)
        for (int l = 0; l < 4; l++)
          if (p[l] && b[2*l +: 2] == 2'(bk)) begin g[l] = 1'b1; break; end
      free_q = {};
      for (int bk = 0; bk < 4; bk++) begin
        busy = 0;
        for (int l = 0; l < 4; l++) if (g[l] && b[2*l +: 2] == 2'(bk)) busy = 1;
        if (!busy) free_q.push_back(bk);
      end
      ob = '0;
      for (int l = 0; l < 4; l++)
        if (g[l]) ob[2*l +: 2] = b[2*l +: 2];
        else      ob[2*l +: 2] = 2'(free_q.pop_front());
      exp_en[n] = g;
      exp_ob[n] = ob;
      n++;
      p &= ~g;
    end
    exp_n = n;
  endtask

  // Called and returns at a negative edge.
  task automatic run_group(input logic [7:0] b, input logic [4*AW-1:0] a,
                           input logic [3:0] m, input int stall_pct, input int hold0);
    int beat, cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("in_ready_before_group", 32'(in_ready), 32'd1);
    in_valid = 1; in_bank = b; in_addr = a; in_mask = m; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    if (exp_n == 0) begin
      check("empty_group_no_beat", 32'(out_valid), 32'd0);
      check("empty_group_ready", 32'(in_ready), 32'd1);
      return;
    end
    check("first_beat_latency", 32'(out_valid), 32'd1);
    beat = 0; cyc = 0;
    while (beat < exp_n && cyc < 400) begin
      if (!out_valid) begin
        check("beat_valid", 32'(out_valid), 32'd1);
        break;
      end
      check("lane_en", 32'(out_lane_en), 32'(exp_en[beat]));
      if (chk_ob_all || beat == 0) check("out_bank", 32'(out_bank), 32'(exp_ob[beat]));
      check("bank_perm", 32'(is_perm(out_bank)), 32'd1);
      check("out_addr", 32'(out_addr), 32'(a));
      check("out_last", 32'(out_last), 32'(beat == exp_n - 1));
      if (beat == 0 && cyc < hold0) out_ready = 0;
      else out_ready = ($urandom_range(99) >= 32'(stall_pct));
      if (out_ready) begin
`ifdef SCHED_STATS_EN
        if (beat != exp_n - 1) stall_exp++;
`endif
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    check("beats_completed", 32'(beat), 32'(exp_n));
    out_ready = 0;
    check("idle_after_group", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4*AW-1:0] a1, a2;
    rst_n = 0; in_valid = 0; in_bank = '0; in_addr = '0; in_mask = '0; out_ready = 0;
`ifdef SCHED_STATS_EN
    stats_clr = 0;
`endif
    tbl[0] = '{8'hE4, 4'hF, 1, 16'h000F, 8'hE4, 0};
    tbl[1] = '{8'hAA, 4'hF, 4, 16'h8421, 8'hD2, 3};
    tbl[2] = '{8'h05, 4'hF, 2, 16'h00A5, 8'hC9, 0};
    tbl[3] = '{8'h1B, 4'h0, 0, 16'h0000, 8'hE4, 0};
    tbl[4] = '{8'hE4, 4'hF, 1, 16'h000F, 8'hE4, 0};
    tbl[5] = '{8'hFF, 4'h6, 2, 16'h0042, 8'h9C, 0};

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_bank", 32'(out_bank), 32'hE4);
    check("rst_lane_en", 32'(out_lane_en), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_release", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      exp_n = tbl[i].n;
      for (int k = 0; k < 4; k++) exp_en[k] = tbl[i].en[4*k +: 4];
      exp_ob[0] = tbl[i].ob1;
      chk_ob_all = 0;
      run_group(tbl[i].bank, 24'($urandom), tbl[i].mask, 0, tbl[i].hold0);
    end

    // Back-to-back: new group latched on the edge that takes the last beat
    a1 = 24'($urandom); a2 = 24'($urandom);
    in_valid = 1; in_bank = 8'hE4; in_mask = 4'hF; in_addr = a1; out_ready = 1;
    @(negedge clk);
    check("b2b_a_lane_en", 32'(out_lane_en), 32'hF);
    check("b2b_a_last", 32'(out_last), 32'd1);
    check("b2b_ready_on_last", 32'(in_ready), 32'd1);
    in_bank = 8'hAA; in_mask = 4'h3; in_addr = a2;
    @(negedge clk);
    in_valid = 0;
    check("b2b_b_valid", 32'(out_valid), 32'd1);
    check("b2b_b_lane_en1", 32'(out_lane_en), 32'h1);
    check("b2b_b_addr", 32'(out_addr), 32'(a2));
    check("b2b_busy_not_ready", 32'(in_ready), 32'd0);
`ifdef SCHED_STATS_EN
    stall_exp++;
`endif
    @(negedge clk);
    check("b2b_b_lane_en2", 32'(out_lane_en), 32'h2);
    check("b2b_b_last", 32'(out_last), 32'd1);
    @(negedge clk);
    out_ready = 0;
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Randomized groups against the reference model
    chk_ob_all = 1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      logic [3:0] m;
      b = 8'($urandom);
      m = 4'($urandom);
      model(b, m);
      run_group(b, 24'($urandom), m, 30, 0);
    end

`ifdef SCHED_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
    stats_clr = 1;
    @(negedge clk);
    stats_clr = 0;
    check("stall_cnt_clear", 32'(stall_cnt), 32'd0);
`endif

    // Reset during beat 2 of a four-beat group
    in_valid = 1; in_bank = 8'hAA; in_mask = 4'hF; in_addr = 24'($urandom); out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    check("rstmid_beat1", 32'(out_lane_en), 32'h1);
    @(negedge clk);
    check("rstmid_beat2", 32'(out_lane_en), 32'h2);
    rst_n = 0;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_ready", 32'(in_ready), 32'd0);
    check("rstmid_lane_en", 32'(out_lane_en), 32'd0);
    check("rstmid_last", 32'(out_last), 32'd0);
    check("rstmid_bank", 32'(out_bank), 32'hE4);
    check("rstmid_addr", 32'(out_addr), 32'd0);
`ifdef SCHED_STATS_EN
    check("rstmid_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rstmid_ready_release", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rstmid_no_beats", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    out_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_access_scheduler.md
# bank_access_scheduler

Upstream companion of the four-lane bank arbiter in the Kyber polynomial datapath. It accepts a group of up to four coefficient accesses (bank index plus word address per lane). It splits the group into conflict-free beats: in every beat each bank is used by at most one enabled lane, and the four bank indices form a permutation of {0,1,2,3}. The arbiter downstream therefore always produces a one-to-one lane-to-bank select.

## Interface
Parameters:
- AW, 6: word address width inside one bank (64 words × 4 banks = 256 coefficients).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  a group is presented.
- in_ready  out  1  the scheduler can accept a group.
- in_bank  in  8  lane i bank index in bits [2i+1:2i].
- in_addr  in  4*AW  lane i word address in bits [AW*i+AW-1:AW*i].
- in_mask  in  4  lane i active when bit i is set.
- out_valid  out  1  a beat is presented.
- out_ready  in  1  the downstream stage takes the beat.
- out_bank  out  8  per-lane bank index (the arbiter's a0..a3); always a permutation.
- out_addr  out  4*AW  per-lane word address, passed through from the latched group.
- out_lane_en  out  4  lanes granted in this beat (write/read enable gating).
- out_last  out  1  this beat completes the group.

## Operation
- Two states:
  - IDLE: in_ready=1.
  - ISSUE: holds the latched group and pending mask P.
- IDLE transitions:
  - On in_valid&&in_ready with in_mask≠0: latch bank, addr and mask; set P=in_mask; go to ISSUE.
  - With in_mask=0: the group is consumed and no beat is produced; stay in IDLE.
- Grant rule: scan lanes 0→3. Grant lane i if P[i]=1 and its bank is not already taken by a lower granted lane. Lane 0 always wins when pending, matching the arbiter's lowest-lane priority.
- Bank fill for out_bank:
  - Granted lanes drive their own bank.
  - Non-granted lanes, in ascending lane order, take the unused banks in ascending order.
- Beat transfer: on out_valid&&out_ready, P ← P & ~out_lane_en.
  - If the result is 0: out_last=1 for that beat; return to IDLE.
  - Otherwise: stay in ISSUE and recompute the grant for the next beat.
- Back-to-back groups: in_ready is also 1 in ISSUE when out_last&&out_ready. A new group is then latched at the same edge, with no bubble.
- Beat count per group equals the maximum number of active lanes sharing one bank (1 to 4).
- out_addr is unmodified; address arithmetic is outside this block.

## Timing
- While rst_n=0: state=IDLE, P=0, out_valid=0, out_lane_en=0, out_last=0, out_bank=8'b11_10_01_00 (identity), out_addr=0, in_ready=0.
- Deassertion of reset is synchronised by the caller. in_ready rises in the first cycle after release.
- Latency: a group accepted at edge N produces its first beat with out_valid=1 in cycle N+1. All out_* signals are registered.
- Under backpressure (out_valid&&!out_ready), every out_* signal holds stable.
- A new grant is presented the cycle after each accepted beat.
- Group throughput: one group per k cycles, where k is the group's beat count.
- Asserting rst_n mid-group discards the group with no further beats.

## Configuration
- SCHED_STATS_EN defined:
  - Adds output stall_cnt[15:0], which counts accepted beats with out_last=0, i.e. the extra cycles caused by bank conflicts.
  - It saturates at 16'hFFFF and resets to 0.
  - Adds input stats_clr, a synchronous clear; clear wins over a same-cycle increment.
- SCHED_STATS_EN undefined: neither port exists, and the datapath behaviour is identical.

## Structure
- Shared package kyber_sched_pkg: LANES=4, BANKS=4, BANK_W=2, and the state enum {S_IDLE, S_ISSUE}.
- Sub-module sched_grant (combinational):
  - Inputs: P and the four bank indices.
  - Outputs: the grant mask and the filled out_bank permutation.
  - Instantiated once; the register and handshake logic stays in the top module.

## Test plan
- in_bank={3,2,1,0} (lane3..lane0), mask=4'hF → one beat: lane_en=4'hF, out_bank unchanged, out_last=1, first out_valid one cycle after accept.
- All lanes bank 2, mask=4'hF → four beats with lane_en 0001, 0010, 0100, 1000. In beat 1 out_bank(lane3..0)={3,1,0,2}. out_last only on beat 4.
- Lanes 0,1 on bank 1 and lanes 2,3 on bank 0 → beat 1 lane_en=0101, beat 2 lane_en=1010. Every beat's out_bank is a permutation.
- out_ready low for 3 cycles during beat 1 → out_* stable throughout. With SCHED_STATS_EN, stall_cnt advances by exactly the number of non-last beats.
- A mask=0 group followed by a full group presented on the next cycle → no beat for the empty group; the second group's beat appears one cycle after its accept.
- rst_n pulsed low during beat 2 of a 4-beat group → out_valid=0 immediately, outputs at reset values, in_ready=1 one cycle after release, no remaining beats.
